counter_sequencer: RTL and testbench

//  Command-driven sequencer for one cascadable up/down counter (EN/PL/INC/DEC, active-low

---
 rtl/counter_seq_pkg.sv | 19 +
 rtl/seq_step_cnt.sv | 42 ++++
 rtl/counter_sequencer.sv | 176 +++++++++++++++++
 tb/tb_counter_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: command op codes and FSM states.
package counter_seq_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_LOAD  = 2'b00;
    localparam logic [OP_W-1:0] OP_UP    = 2'b01;
    localparam logic [OP_W-1:0] OP_DOWN  = 2'b10;
    localparam logic [OP_W-1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CLR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_step_cnt.sv
// Loadable down-counter that tracks the remaining COUNT steps.
// Holds when dec is low and never decrements below zero.
module seq_step_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_last,
    output logic         is_zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement; zero is a floor.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign is_last = (count_q == {{(W-1){1'b0}}, 1'b1});
    assign is_zero = (count_q == '0);

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a cascadable up/down counter. Accepts
// LOAD / COUNT_UP / COUNT_DOWN / CLEAR over valid/ready and drives the
// counter control pins cycle by cycle, tracking wrap and abort status.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            RES,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [W-1:0]    cmd_data,
    input  logic            pause,
    input  logic            abort,
    input  logic [W-1:0]    cnt_q,
    input  logic            cnt_co,
    output logic            cnt_res,
    output logic            cnt_en,
    output logic            cnt_pl,
    output logic            cnt_inc,
    output logic            cnt_dec,
    output logic            cnt_ci_n,
    output logic [W-1:0]    cnt_di,
    output logic            busy,
    output logic            done,
    output logic            wrapped,
    output logic            aborted,
    output logic [W-1:0]    steps_left
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [W-1:0]    di_q, di_d;
    logic            wrapped_q, wrapped_d;
    logic            aborted_q, aborted_d;

    logic            step_load;
    logic            step_dec;
    logic            step_last;
    logic            step_zero;

    // The readback stays on the port for host observability; wrap detection
    // relies on CarryOut alone, so the value itself is not consumed here.
    logic            unused_readback;
    assign unused_readback = ^cnt_q;

    seq_step_cnt #(
        .W (W)
    ) u_step_cnt (
        .clk      (clk),
        .srst     (RES),
        .load     (step_load),
        .load_val (cmd_data),
        .dec      (step_dec),
        .count    (steps_left),
        .is_last  (step_last),
        .is_zero  (step_zero)
    );

    // Next-state logic: command accept, step bookkeeping, sticky flags.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        di_d      = di_q;
        wrapped_d = wrapped_q;
        aborted_d = aborted_q;
        step_load = 1'b0;
        step_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    wrapped_d = 1'b0;
                    aborted_d = 1'b0;
                    case (cmd_op)
                        OP_LOAD: begin
                            di_d    = cmd_data;
                            state_d = ST_LOAD;
                        end
                        OP_UP, OP_DOWN: begin
                            step_load = 1'b1;
                            state_d   = (cmd_data == '0) ? ST_DONE : ST_RUN;
                        end
                        default: begin
                            state_d = ST_CLR;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                // Load pins are driven this cycle whether or not abort is up.
                if (abort) begin
                    aborted_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_RUN: begin
                // An unpaused cycle always steps the counter, even when aborting.
                if (!pause && !step_zero) begin
                    step_dec  = 1'b1;
                    wrapped_d = wrapped_q | cnt_co;
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (step_zero) begin
                    state_d = ST_DONE;
                end else if (!pause && step_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_CLR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RES) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            di_q      <= '0;
            wrapped_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            di_q      <= di_d;
            wrapped_q <= wrapped_d;
            aborted_q <= aborted_d;
        end
    end

    // Counter pin decode from state, latched op and the pause input.
    always_comb begin
        cnt_res  = RES | (state_q == ST_CLR);
        cnt_en   = 1'b0;
        cnt_pl   = 1'b0;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        cnt_ci_n = 1'b1;
        case (state_q)
            ST_LOAD: begin
                cnt_en = 1'b1;
                cnt_pl = 1'b1;
            end
            ST_RUN: begin
                if (!pause) begin
                    cnt_en   = 1'b1;
                    cnt_ci_n = 1'b0;
                    cnt_inc  = (op_q == OP_UP);
                    cnt_dec  = (op_q == OP_DOWN);
                end
            end
            default: begin
            end
        endcase
    end

    assign cnt_di    = di_q;
    assign cmd_ready = (state_q == ST_IDLE) & ~RES;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign wrapped   = wrapped_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural up/down counter.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       RES;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       pause;
    logic       abort;
    logic [7:0] cnt_q;
    logic       cnt_co;
    logic       cnt_res, cnt_en, cnt_pl, cnt_inc, cnt_dec, cnt_ci_n;
    logic [7:0] cnt_di;
    logic       busy, done, wrapped, aborted;
    logic [7:0] steps_left;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the most recent run_cmd
    int         busy_cyc, done_cnt, en_cnt, res_cnt, done_c;
    logic [7:0] qtrace[$];
    int         acc_c, ready_busy;

    always #5 clk = ~clk;

    counter_sequencer #(.W(8)) dut (
        .clk        (clk),
        .RES        (RES),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .pause      (pause),
        .abort      (abort),
        .cnt_q      (cnt_q),
        .cnt_co     (cnt_co),
        .cnt_res    (cnt_res),
        .cnt_en     (cnt_en),
        .cnt_pl     (cnt_pl),
        .cnt_inc    (cnt_inc),
        .cnt_dec    (cnt_dec),
        .cnt_ci_n   (cnt_ci_n),
        .cnt_di     (cnt_di),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped),
        .aborted    (aborted),
        .steps_left (steps_left)
    );

    // Behavioural cascadable counter: RES clears, PL loads, CarryIn low counts.
    always @(posedge clk) begin
        if (cnt_res) begin
            cnt_q <= 8'h00;
        end else if (cnt_en) begin
            if (cnt_pl) begin
                cnt_q <= cnt_di;
            end else if (!cnt_ci_n) begin
                if (cnt_inc) cnt_q <= cnt_q + 8'h01;
                else if (cnt_dec) cnt_q <= cnt_q - 8'h01;
            end
        end
    end
    assign cnt_co = cnt_en && !cnt_ci_n && !cnt_pl &&
                    ((cnt_inc && cnt_q == 8'hFF) || (cnt_dec && cnt_q == 8'h00));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Present a command and wait (bounded) for it to be accepted.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        bit accepted = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
        end
        check("accept", 32'(accepted), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Issue one command and watch it until its done pulse. Cycle c counts from
    // the accept edge; pause is high for c in [pause_at, pause_at+pause_len),
    // abort is high for c == abort_at (negative disables either).
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                           input int pause_at, input int pause_len, input int abort_at);
        busy_cyc = 0; done_cnt = 0; en_cnt = 0; res_cnt = 0; done_c = -1;
        qtrace.delete();
        send(op, data);
        for (int c = 0; c < 60; c++) begin
            pause = (pause_at >= 0) && (c >= pause_at) && (c < pause_at + pause_len);
            abort = (c == abort_at);
            @(negedge clk);
            qtrace.push_back(cnt_q);
            if (cnt_en)  en_cnt++;
            if (cnt_res) res_cnt++;
            if (done) begin
                done_cnt++;
                done_c = c;
            end else if (busy) begin
                busy_cyc++;
            end
            @(posedge clk); #1;
            if (done_c >= 0) break;
        end
        pause = 1'b0;
        abort = 1'b0;
        check("done_seen", 32'(done_cnt), 32'd1);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        RES = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        pause = 1'b0; abort = 1'b0;

        // 1. Reset
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_cnt_res", 32'(cnt_res), 32'd1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        RES = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_ci_n", 32'(cnt_ci_n), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_cnt_q", 32'(cnt_q), 32'h00);
        check("post_rst_steps", 32'(steps_left), 32'h00);
        @(posedge clk); #1;

        // 2. LOAD FE, COUNT_UP 3
        run_cmd(2'b00, 8'hFE, -1, 0, -1);
        check("load_fe_q", 32'(qtrace[1]), 32'hFE);
        check("load_fe_busy", 32'(busy_cyc), 32'd1);
        run_cmd(2'b01, 8'd3, -1, 0, -1);
        check("up3_q0", 32'(qtrace[0]), 32'hFE);
        check("up3_q1", 32'(qtrace[1]), 32'hFF);
        check("up3_q2", 32'(qtrace[2]), 32'h00);
        check("up3_q3", 32'(qtrace[3]), 32'h01);
        check("up3_run_cycles", 32'(busy_cyc), 32'd3);
        check("up3_wrapped", 32'(wrapped), 32'd1);
        check("up3_steps_left", 32'(steps_left), 32'h00);

        // 3. LOAD 01, COUNT_DOWN 2, COUNT_UP 1
        run_cmd(2'b00, 8'h01, -1, 0, -1);
        run_cmd(2'b10, 8'd2, -1, 0, -1);
        check("dn2_q1", 32'(qtrace[1]), 32'h00);
        check("dn2_q2", 32'(qtrace[2]), 32'hFF);
        check("dn2_wrapped", 32'(wrapped), 32'd1);
        run_cmd(2'b01, 8'd1, -1, 0, -1);
        check("up1_q", 32'(qtrace[1]), 32'h00);
        check("up1_wrapped", 32'(wrapped), 32'd1);
        check("up1_run_cycles", 32'(busy_cyc), 32'd1);

        // 4. LOAD 10, COUNT_UP 5 with a 3-cycle pause after step 2
        run_cmd(2'b00, 8'h10, -1, 0, -1);
        run_cmd(2'b01, 8'd5, 2, 3, -1);
        check("pause_run_cycles", 32'(busy_cyc), 32'd8);
        check("pause_en_cycles", 32'(en_cnt), 32'd5);
        check("pause_final_q", 32'(qtrace[qtrace.size()-1]), 32'h15);
        check("pause_wrapped", 32'(wrapped), 32'd0);
        check("pause_aborted", 32'(aborted), 32'd0);

        // 5. LOAD 00, COUNT_DOWN 10, abort during the second step
        run_cmd(2'b00, 8'h00, -1, 0, -1);
        run_cmd(2'b10, 8'd10, -1, 0, 1);
        check("abort_flag", 32'(aborted), 32'd1);
        check("abort_q", 32'(cnt_q), 32'hFE);
        check("abort_steps_left", 32'(steps_left), 32'h08);
        check("abort_wrapped", 32'(wrapped), 32'd1);
        check("abort_done_cycle", 32'(done_c), 32'd2);

        // 6. COUNT_UP 0, CLEAR, held cmd_valid while busy
        run_cmd(2'b01, 8'd0, -1, 0, -1);
        check("cnt0_done_lat", 32'(done_c), 32'd0);
        check("cnt0_en_cycles", 32'(en_cnt), 32'd0);
        check("cnt0_steps_left", 32'(steps_left), 32'h00);
        check("cnt0_aborted_clr", 32'(aborted), 32'd0);
        check("cnt0_q_held", 32'(cnt_q), 32'hFE);
        run_cmd(2'b11, 8'h00, -1, 0, -1);
        check("clr_res_cycles", 32'(res_cnt), 32'd1);
        check("clr_q", 32'(cnt_q), 32'h00);

        send(2'b01, 8'd4);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h33;
        acc_c = -1; ready_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cmd_ready && busy) ready_busy++;
            if (cmd_ready) begin
                acc_c = c;
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check("held_accept_cycle", 32'(acc_c), 32'd5);
        check("held_ready_busy", 32'(ready_busy), 32'd0);
        @(negedge clk);
        check("held_load_pl", 32'(cnt_pl), 32'd1);
        check("held_pre_load_q", 32'(cnt_q), 32'h04);
        @(posedge clk); #1;
        @(negedge clk);
        check("held_load_q", 32'(cnt_q), 32'h33);
        check("held_done", 32'(done), 32'd1);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
